// File: rtl/t07_mem_responder_pkg.sv
// Shared types and constants for the memory responder: request encoding,
// responder states and the poison word returned by an aborted access.
package t07_mem_pkg;

  typedef enum logic [1:0] {
    RWI_IDLE  = 2'b00,
    RWI_WRITE = 2'b01,
    RWI_READ  = 2'b10,
    RWI_FETCH = 2'b11
  } rwi_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } resp_state_t;

  localparam logic [31:0] MEM_POISON = 32'hDEADBEEF;

endpackage

// File: rtl/t07_mem_responder_timer.sv
// Access watchdog counter: cleared on entry to REQ, counts while enabled and
// raises a terminal-count flag after MAX counted cycles.
module t07_memRespTimer #(
  parameter int unsigned MAX = 255
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = (MAX > 1) ? $clog2(MAX) : 1;

  logic [W-1:0] r_cnt;
  logic         w_tc;

  // Terminal count is reached after MAX-1 increments, so the abort edge is
  // the MAX-th clock edge spent in REQ.
  assign w_tc = (r_cnt == W'(MAX - 1));
  assign o_tc = w_tc;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/t07_mem_responder.sv
// Memory-side responder for the rwi/busy handshake; completion is the falling
// edge of busy_o. Optional access timeout under T07_MEMRESP_TIMEOUT_EN.
module t07_mem_responder
  import t07_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [1:0]  rwi_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] data_i,
  output logic        busy_o,
  output logic [31:0] data_o,
  output logic [31:0] instr_o,
  output logic [31:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  output logic        mem_we_o,
  output logic        mem_stb_o,
  input  logic [31:0] mem_dat_i,
  input  logic        mem_ack_i,
  output logic        timeout_o
);

  // Handshake: a request level on rwi_i starts one access; the access owns the
  // captured op/address/data until busy_o falls, and the same level must change
  // before another access can start.

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  resp_state_t r_state;
  rwi_t        r_op;
  logic        r_busy;
  logic        r_stb;
  logic        r_we;
  logic [31:0] r_adr;
  logic [31:0] r_wdat;
  logic [31:0] r_data;
  logic [31:0] r_instr;
  logic        w_start;

  assign w_start = (r_state == IDLE) && (rwi_i != RWI_IDLE);

`ifdef T07_MEMRESP_TIMEOUT_EN
  logic r_timeout;
  logic w_tc;

  t07_memRespTimer #(
    .MAX (TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .nrst  (nrst),
    .i_clr (w_start),
    .i_en  (r_state == REQ),
    .o_tc  (w_tc)
  );

  assign timeout_o = r_timeout;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= IDLE;
      r_op      <= RWI_IDLE;
      r_busy    <= 1'b0;
      r_stb     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_data    <= '0;
      r_instr   <= '0;
`ifdef T07_MEMRESP_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
    end else begin
`ifdef T07_MEMRESP_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= REQ;
            r_op    <= rwi_t'(rwi_i);
            r_adr   <= (rwi_i == RWI_FETCH) ? pc_i : addr_i;
            r_wdat  <= data_i;
            r_busy  <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= (rwi_i == RWI_WRITE);
          end
        end
        REQ: begin
          // Ack wins over a timeout that expires on the same edge.
          if (mem_ack_i) begin
            r_state <= HOLD;
            r_busy  <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            if (r_op == RWI_READ)  r_data  <= mem_dat_i;
            if (r_op == RWI_FETCH) r_instr <= mem_dat_i;
          end
`ifdef T07_MEMRESP_TIMEOUT_EN
          else if (w_tc) begin
            r_state   <= HOLD;
            r_busy    <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_timeout <= 1'b1;
            if (r_op == RWI_READ)  r_data  <= MEM_POISON;
            if (r_op == RWI_FETCH) r_instr <= MEM_POISON;
          end
`endif
        end
        HOLD: begin
          if (rwi_i != r_op) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o    = r_busy;
  assign mem_stb_o = r_stb;
  assign mem_we_o  = r_we;
  assign mem_adr_o = r_adr;
  assign mem_dat_o = r_wdat;
  assign data_o    = r_data;
  assign instr_o   = r_instr;

endmodule

// File: tb/tb_t07_mem_responder.sv
// Self-checking bench for t07_mem_responder; timeout scenario is exercised
// only when T07_MEMRESP_TIMEOUT_EN is defined.
module tb_t07_mem_responder;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        nrst;
  logic [1:0]  rwi_i;
  logic [31:0] addr_i, pc_i, data_i;
  logic        busy_o;
  logic [31:0] data_o, instr_o, mem_adr_o, mem_dat_o;
  logic        mem_we_o, mem_stb_o;
  logic [31:0] mem_dat_i;
  logic        mem_ack_i;
  logic        timeout_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] m_data  = '0;
  logic [31:0] m_instr = '0;

  logic stb_prev  = 1'b0;
  int   stb_rises = 0;

  t07_mem_responder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .rwi_i     (rwi_i),
    .addr_i    (addr_i),
    .pc_i      (pc_i),
    .data_i    (data_i),
    .busy_o    (busy_o),
    .data_o    (data_o),
    .instr_o   (instr_o),
    .mem_adr_o (mem_adr_o),
    .mem_dat_o (mem_dat_o),
    .mem_we_o  (mem_we_o),
    .mem_stb_o (mem_stb_o),
    .mem_dat_i (mem_dat_i),
    .mem_ack_i (mem_ack_i),
    .timeout_o (timeout_o)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  always @(negedge clk) begin
    if (mem_stb_o && !stb_prev) stb_rises++;
    stb_prev = mem_stb_o;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access; n = REQ cycle in which ack arrives (0 = never, expect timeout).
  task automatic do_access(input logic [1:0] op, input logic [31:0] a, input logic [31:0] p,
                           input logic [31:0] wd, input logic [31:0] rd, input int n,
                           input bit from_hold, input bit disturb, input bit release_req);
    logic [31:0] exp_adr, val, exp_d, exp_i;
    int busy_cnt;
    exp_adr = (op == 2'b11) ? p : a;
    val = (n == 0) ? 32'hDEADBEEF : rd;
    if (op == 2'b10) m_data = val;
    if (op == 2'b11) m_instr = val;
    exp_q.push_back(m_data);
    exp_q.push_back(m_instr);
    rwi_i = op; addr_i = a; pc_i = p; data_i = wd; mem_ack_i = 1'b0;
    @(negedge clk);
    if (from_hold) begin
      check("idle_gap_busy", {31'b0, busy_o}, 32'd0);
      @(negedge clk);
    end
    check("req_stb", {31'b0, mem_stb_o}, 32'd1);
    check("req_adr", mem_adr_o, exp_adr);
    check("req_we", {31'b0, mem_we_o}, {31'b0, (op == 2'b01)});
    check("req_dat", mem_dat_o, wd);
    if (disturb) begin
      rwi_i = 2'b00; addr_i = 32'h0000FFFF; pc_i = ~p; data_i = ~wd;
    end
    busy_cnt = 0;
    while (busy_o === 1'b1 && busy_cnt < 64) begin
      busy_cnt++;
      if (busy_cnt == n) begin
        mem_ack_i = 1'b1;
        mem_dat_i = rd;
      end
      @(negedge clk);
      mem_ack_i = 1'b0;
    end
    check("busy_len", busy_cnt, (n == 0) ? TMO : n);
    check("timeout_o", {31'b0, timeout_o}, {31'b0, (n == 0)});
    check("done_stb", {31'b0, mem_stb_o}, 32'd0);
    check("done_we", {31'b0, mem_we_o}, 32'd0);
    check("hold_adr", mem_adr_o, exp_adr);
    check("hold_dat", mem_dat_o, wd);
    exp_d = exp_q.pop_front();
    exp_i = exp_q.pop_front();
    check("data_o", data_o, exp_d);
    check("instr_o", instr_o, exp_i);
    if (release_req) begin
      rwi_i = 2'b00;
      @(negedge clk);
      check("release_timeout", {31'b0, timeout_o}, 32'd0);
    end
  endtask

  initial begin
    int r0;
    logic [1:0] rop;
    nrst = 1'b0; rwi_i = '0; addr_i = '0; pc_i = '0; data_i = '0;
    mem_dat_i = '0; mem_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy_o}, 32'd0);
    check("rst_stb", {31'b0, mem_stb_o}, 32'd0);
    check("rst_data", data_o, 32'd0);
    check("rst_instr", instr_o, 32'd0);
    check("rst_adr", mem_adr_o, 32'd0);
    check("rst_timeout", {31'b0, timeout_o}, 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    // fetch, 3-cycle busy
    do_access(2'b11, 32'h0, 32'h100, 32'h0, 32'h00500093, 3, 0, 0, 1);
    // write, ack in first cycle
    do_access(2'b01, 32'h2004, 32'h0, 32'hCAFEF00D, 32'h11111111, 1, 0, 0, 1);

    // ack while idle is ignored
    mem_ack_i = 1'b1; mem_dat_i = 32'hBAD0BAD0;
    repeat (2) @(negedge clk);
    mem_ack_i = 1'b0;
    check("idle_ack_busy", {31'b0, busy_o}, 32'd0);
    check("idle_ack_data", data_o, m_data);

    // held read level: one strobe only, ack in HOLD ignored
    r0 = stb_rises;
    do_access(2'b10, 32'h3000, 32'h0, 32'h0, 32'hA5A50001, 2, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin mem_ack_i = 1'b1; mem_dat_i = 32'hBAD1BAD1; end
      @(negedge clk);
      mem_ack_i = 1'b0;
      check("held_busy", {31'b0, busy_o}, 32'd0);
    end
    check("held_strobes", stb_rises - r0, 32'd1);
    check("held_data", data_o, m_data);
    // new fetch from HOLD after one idle cycle
    do_access(2'b11, 32'h0, 32'h200, 32'h0, 32'h00A00113, 2, 1, 0, 1);

    // rwi/addr change during REQ
    do_access(2'b10, 32'h4000, 32'h0, 32'h77, 32'h1234, 2, 0, 1, 1);

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(1, 3));
      do_access(rop, $urandom, $urandom, $urandom, $urandom, $urandom_range(1, 4), 0, 0, 1);
    end

    // reset mid-access
    rwi_i = 2'b10; addr_i = 32'h5000;
    @(negedge clk);
    check("mid_busy", {31'b0, busy_o}, 32'd1);
    nrst = 1'b0;
    #1;
    m_data = '0; m_instr = '0;
    check("arst_stb", {31'b0, mem_stb_o}, 32'd0);
    check("arst_busy", {31'b0, busy_o}, 32'd0);
    check("arst_we", {31'b0, mem_we_o}, 32'd0);
    check("arst_adr", mem_adr_o, 32'd0);
    check("arst_dat", mem_dat_o, 32'd0);
    check("arst_data", data_o, m_data);
    check("arst_instr", instr_o, m_instr);
    rwi_i = 2'b00; mem_ack_i = 1'b1; mem_dat_i = 32'hBAD2BAD2;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    check("late_ack_busy", {31'b0, busy_o}, 32'd0);
    check("late_ack_data", data_o, m_data);

`ifdef T07_MEMRESP_TIMEOUT_EN
    do_access(2'b10, 32'h6000, 32'h0, 32'h0, 32'h0, 0, 0, 0, 1);
    do_access(2'b01, 32'h6004, 32'h0, 32'h55AA55AA, 32'h0, 0, 0, 0, 1);
    do_access(2'b11, 32'h0, 32'h300, 32'h0, 32'h0, 0, 0, 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/t07_mem_responder.md
# t07_mem_responder

Memory-side responder for the CPU memory handler's `rwi`/`busy` protocol. It accepts fetch, read and write requests, runs one single-beat access on a strobe/ack external memory port, and returns instruction or read data. It signals completion with a falling edge on `busy_o`, which is the edge the handler waits for. It sits between the memory handler and the SRAM/MMIO fabric.

## Interface
- `TIMEOUT_CYCLES`, default 255: maximum cycles in REQ without `mem_ack_i`. Used only when the timeout feature is compiled in.
- `clk`, in, 1: clock.
- `nrst`, in, 1: reset, asynchronous, active-low.
- `rwi_i`, in, 2: request type. `00` idle, `01` write, `10` read, `11` fetch.
- `addr_i`, in, 32: read/write byte address.
- `pc_i`, in, 32: fetch address.
- `data_i`, in, 32: write data.
- `busy_o`, out, 1: high while an access is in flight.
- `data_o`, out, 32: last read data.
- `instr_o`, out, 32: last fetched instruction.
- `mem_adr_o`, out, 32: external address.
- `mem_dat_o`, out, 32: external write data.
- `mem_we_o`, out, 1: external write enable.
- `mem_stb_o`, out, 1: external request strobe.
- `mem_dat_i`, in, 32: external read data.
- `mem_ack_i`, in, 1: external completion.
- `timeout_o`, out, 1: one-cycle pulse on access abort.

## Operation
- States:
  - IDLE (0): no access in flight.
  - REQ (1): access issued, waiting for ack.
  - HOLD (2): access done, waiting for the request to change.
- IDLE → REQ when `rwi_i != 00`. On that edge, capture:
  - `op_q = rwi_i`.
  - Address: `pc_i` for fetch, `addr_i` otherwise.
  - `data_i`.
- REQ outputs: `busy_o=1`, `mem_stb_o=1`, `mem_adr_o`=captured address, `mem_we_o=(op_q==01)`, `mem_dat_o`=captured data.
- REQ → HOLD on `mem_ack_i`. On the same edge:
  - Read: `data_o <= mem_dat_i`.
  - Fetch: `instr_o <= mem_dat_i`.
  - Write: both outputs unchanged.
- HOLD → IDLE when `rwi_i != op_q`. A request level held steady never re-triggers.
- Outside REQ: `mem_stb_o=0`, `mem_we_o=0`, `busy_o=0`. `mem_adr_o` and `mem_dat_o` hold their last values.
- Boundary conditions:
  - `mem_ack_i` in IDLE or HOLD is ignored.
  - Changes to `rwi_i`, `addr_i` or `data_i` during REQ are ignored; the access uses the captured values. This includes `rwi_i` dropping to `00`.
  - A new request arriving while in HOLD is served after one IDLE cycle.
- Reset, including mid-access:
  - State → IDLE; `mem_stb_o` drops asynchronously.
  - All outputs reset to 0: `busy_o`, `data_o`, `instr_o`, `mem_adr_o`, `mem_dat_o`, `mem_we_o`, `mem_stb_o`, `timeout_o`.
  - `op_q` resets to `00`.

## Timing
- All outputs are registered or decoded from state only; there is no input→output combinational path.
- Request seen at edge N → `busy_o` and `mem_stb_o` high from N+1.
- Ack sampled at edge M → `busy_o` low and data valid from M+1. The handler's falling-edge detector fires at M+1.
- Minimum `busy_o` pulse is 1 cycle (ack in the first REQ cycle).
- `data_o` and `instr_o` are stable from capture until the next capture of the same kind.

## Configuration
- `T07_MEMRESP_TIMEOUT_EN` defined:
  - A cycle counter runs in REQ and clears on entering REQ.
  - If the count reaches `TIMEOUT_CYCLES` with no ack, the access is aborted and the block goes to HOLD.
  - On abort, a read loads `32'hDEADBEEF` into `data_o` and a fetch loads it into `instr_o`; a write loses its data.
  - `timeout_o` pulses for 1 cycle, aligned with `busy_o` falling.
- Not defined:
  - REQ waits indefinitely for ack.
  - There is no counter; `timeout_o` is tied to 0.
  - The port list is identical in both builds.

## Structure
- Package `t07_mem_pkg` holds:
  - `rwi_t` enum: `RWI_IDLE`, `RWI_WRITE`, `RWI_READ`, `RWI_FETCH`.
  - `resp_state_t` enum: IDLE, REQ, HOLD.
  - Constant `MEM_POISON = 32'hDEADBEEF`.
- One sub-module, `t07_memRespTimer`: counter with clear, enable and terminal-count flag. It is instantiated only under `T07_MEMRESP_TIMEOUT_EN`.

## Test plan
- **Fetch:** `rwi_i=11`, `pc_i=0x100`; ack after 3 cycles with `mem_dat_i=0x00500093` → `mem_adr_o=0x100`, `busy_o` high 3 cycles, `instr_o=0x00500093`, `data_o` unchanged.
- **Write:** `rwi_i=01`, `addr_i=0x2004`, `data_i=0xCAFEF00D`; ack on the first cycle → one-cycle `busy_o`, `mem_we_o=1`, `mem_dat_o=0xCAFEF00D`; `data_o` and `instr_o` unchanged.
- **Held request:** `rwi_i` stays `10` for 10 cycles after completion → exactly one strobe. Then `rwi_i=11` → a new fetch starts after one IDLE cycle.
- **Mid-access changes:** `rwi_i` changes to `00` and `addr_i` to `0xFFFF` during REQ; ack with `0x1234` → `data_o=0x1234`, `mem_adr_o` still the captured address.
- **Reset mid-access:** `nrst` low during REQ → `mem_stb_o` and `busy_o` drop immediately; all outputs read 0; a late ack is ignored.
- **Timeout (macro on, `TIMEOUT_CYCLES=4`):** read with no ack → `busy_o` falls after 4 cycles, `data_o=0xDEADBEEF`, one-cycle `timeout_o` pulse.
